gshare_branch_predictor: RTL and testbench
==========================================

# gshare_branch_predictor

Parametrised next-generation branch predictor for the RV32IM pipeline, sitting beside the fetch stage. Fetch-stage lookup of a tagged direct-mapped BTB and a table of 2-bit saturating counters; non-speculative update from the EX/MEM stage, where the block also judges prediction correctness in both direction and target. Adds tagged entries, configurable depths and widths, saturating performance counters and optional gshare indexing over the earlier fixed 12-bit predictor.

## Interface
- PC_W, 12, PC width in bits
- BTB_ENTRIES, 16, BTB depth (power of two)
- BHT_ENTRIES, 64, counter-table depth (power of two, ≥ BTB_ENTRIES)
- GHR_W, 6, global history width (≤ log2(BHT_ENTRIES); used only with GSHARE_EN)
- CTR_INIT, 2'b01, counter reset value (weakly not-taken)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- pc_in  in  PC_W  fetch PC
- predict_taken  out  1  predicted taken (btb_hit && counter[1])
- btb_hit  out  1  valid entry, tag match
- predict_target  out  PC_W  BTB target (0 when no hit)
- pred_ghr  out  GHR_W  GHR snapshot to carry down the pipe (0 without GSHARE_EN)
- upd_valid  in  1  EX/MEM holds a resolved instruction
- upd_pc  in  PC_W  its PC
- upd_is_branch  in  1  it is a conditional branch
- upd_taken  in  1  branch outcome
- upd_target  in  PC_W  resolved target
- upd_pred_taken  in  1  prediction carried from fetch
- upd_pred_target  in  PC_W  predicted target carried from fetch
- upd_btb_hit  in  1  btb_hit carried from fetch
- upd_ghr  in  GHR_W  pred_ghr carried from fetch (ignored without GSHARE_EN)
- actual_taken  out  1  upd_valid && upd_is_branch && upd_taken
- bpu_correct  out  1  prediction correct (1 when !upd_valid)
- mispredict  out  1  upd_valid && !bpu_correct
- branch_cnt  out  16  resolved-branch count, saturating
- mispred_cnt  out  16  mispredict count, saturating

## Operation
- Indexing: PC word-aligned, bits [1:0] ignored. BTB index = pc[log2(BTB_ENTRIES)+1:2], tag = pc[PC_W-1:log2(BTB_ENTRIES)+2]. BHT index = pc[log2(BHT_ENTRIES)+1:2].
- Lookup (combinational): hit = valid[idx] && tag match. predict_target = target[idx] on hit, else 0.
- bpu_correct = (upd_pred_taken == actual_taken) && (!actual_taken || upd_pred_target == upd_target).
- Update on a clock edge with upd_valid=1:
  - upd_is_branch: BHT counter increments on taken and decrements on not-taken, saturating at 11 and 00.
  - upd_is_branch && upd_taken: BTB entry written (valid=1, tag, upd_target). Overwrites an alias.
  - Not-taken branch: BTB is untouched.
  - !upd_is_branch && upd_btb_hit: BTB entry invalidated (alias eviction).
- Perf counters: branch_cnt +1 per resolved branch; mispred_cnt +1 per mispredict. Both hold at 16'hFFFF.
- Reset (reset=0 at an edge): all valid bits 0, all counters CTR_INIT, GHR 0, perf counters 0. An update presented in a reset cycle is discarded.

## Timing
- Prediction outputs: zero-latency combinational from pc_in and current state.
- Update: becomes visible to lookup on the cycle after the edge that writes it.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents; no bypass.
- actual_taken, bpu_correct and mispredict: combinational from upd_* inputs.
- Outputs after reset: btb_hit=0, predict_taken=0 (given CTR_INIT[1]=0), predict_target=0, pred_ghr=0, counters 0.

## Configuration
- GSHARE_BRANCH_PREDICTOR_GSHARE_EN defined:
  - Lookup BHT index = pc index XOR zero-extended GHR.
  - Update index = upd_pc index XOR upd_ghr.
  - GHR shifts left with actual_taken in the LSB on every resolved branch. The GHR is non-speculative.
  - pred_ghr = GHR.
- Macro undefined: GHR is absent, pred_ghr is tied to 0, upd_ghr is unused, and indexing is PC-only.

## Structure
- Package bpu_pkg holds:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11
  - saturating-counter next-state function
  - 16-bit saturating-increment function
- Index and tag widths are localparams derived in the module.
- One sub-module, bpu_btb_array: valid/tag/target storage with combinational read, synchronous write/invalidate and synchronous reset.

## Test plan
Default parameters throughout.
- Reset: hold reset=0 for 2 cycles, then pc_in=0x040 -> btb_hit=0, predict_taken=0, predict_target=0, branch_cnt=0.
- Allocation: update pc=0x040 branch taken to 0x100, pred_taken=0 -> mispredict=1 that cycle. Next cycle pc_in=0x040 -> btb_hit=1, predict_target=0x100, predict_taken=1 (counter 01->10).
- Saturation: after allocation, 3 not-taken updates at 0x040 -> predict_taken=0, btb_hit=1. A 4th not-taken update keeps the counter at 00. branch_cnt=4.
- Target mispredict: pred_taken=1, pred_target=0x100, actual taken to 0x200 -> bpu_correct=0. Next lookup gives predict_target=0x200.
- Alias: pc_in=0x440 after 0x040 allocated -> btb_hit=0. Non-branch update at 0x040 with upd_btb_hit=1 -> next lookup at 0x040 gives btb_hit=0.
- GSHARE_EN: 3 taken branches -> pred_ghr=6'b000111. An update at 0x040 with upd_ghr=0x07 changes the counter at BHT index 0x10^0x07=0x17 only.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared counter encodings and saturating helpers
// for the gshare branch predictor.
package bpu_pkg;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   function automatic logic [1:0] ctr_next(
      input logic [1:0] c,
      input logic       taken
   );
      if (taken)
         return (c == ST) ? ST : c + 2'd1;
      else
         return (c == SNT) ? SNT : c - 2'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(
      input logic [15:0] v
   );
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/bpu_btb_array.sv
// BTB storage: valid/tag/target with combinational read,
// synchronous write, invalidate and synchronous active-low reset.
module bpu_btb_array #(
   parameter int ENTRIES = 16,
   parameter int TAG_W   = 6,
   parameter int DATA_W  = 12,
   localparam int IW     = $clog2(ENTRIES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IW-1:0]     rd_idx,
   output logic              rd_valid,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [IW-1:0]     wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              inv_en,
   input  logic [IW-1:0]     inv_idx
);

   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tag  [ENTRIES];
   logic [DATA_W-1:0]  data [ENTRIES];

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tag[rd_idx];
   assign rd_data  = data[rd_idx];

   // Valid bits: cleared on reset, set on write, cleared on invalidate
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
      end else if (inv_en) begin
         valid[inv_idx] <= 1'b0;
      end
   end

   // Tag/target payload; only meaningful while valid is set
   always_ff @(posedge clk) begin
      if (reset && wr_en) begin
         tag[wr_idx]  <= wr_tag;
         data[wr_idx] <= wr_data;
      end
   end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Tagged BTB + 2-bit counter predictor with perf counters.
// Optional gshare indexing: GSHARE_BRANCH_PREDICTOR_GSHARE_EN.
module gshare_branch_predictor
   import bpu_pkg::*;
#(
   parameter int         PC_W        = 12,
   parameter int         BTB_ENTRIES = 16,
   parameter int         BHT_ENTRIES = 64,
   parameter int         GHR_W       = 6,
   parameter logic [1:0] CTR_INIT    = WNT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [PC_W-1:0] pc_in,
   output logic            predict_taken,
   output logic            btb_hit,
   output logic [PC_W-1:0] predict_target,
   output logic [GHR_W-1:0] pred_ghr,
   input  logic            upd_valid,
   input  logic [PC_W-1:0] upd_pc,
   input  logic            upd_is_branch,
   input  logic            upd_taken,
   input  logic [PC_W-1:0] upd_target,
   input  logic            upd_pred_taken,
   input  logic [PC_W-1:0] upd_pred_target,
   input  logic            upd_btb_hit,
   input  logic [GHR_W-1:0] upd_ghr,
   output logic            actual_taken,
   output logic            bpu_correct,
   output logic            mispredict,
   output logic [15:0]     branch_cnt,
   output logic [15:0]     mispred_cnt
);

   localparam int BTB_IW = $clog2(BTB_ENTRIES);
   localparam int BHT_IW = $clog2(BHT_ENTRIES);
   localparam int TAG_W  = PC_W - BTB_IW - 2;

   logic [BTB_IW-1:0] lk_btb_idx;
   logic [TAG_W-1:0]  lk_tag;
   logic [BTB_IW-1:0] up_btb_idx;
   logic [TAG_W-1:0]  up_tag;
   logic [BHT_IW-1:0] lk_pidx;
   logic [BHT_IW-1:0] up_pidx;
   logic [BHT_IW-1:0] lk_bidx;
   logic [BHT_IW-1:0] up_bidx;

   logic              rd_valid;
   logic [TAG_W-1:0]  rd_tag;
   logic [PC_W-1:0]   rd_target;

   logic [1:0]        bht [BHT_ENTRIES];

   logic              res_branch;
   logic              btb_wr;
   logic              btb_inv;
   logic              unused_bits;

   assign lk_btb_idx = pc_in[BTB_IW+1:2];
   assign lk_tag     = pc_in[PC_W-1:BTB_IW+2];
   assign up_btb_idx = upd_pc[BTB_IW+1:2];
   assign up_tag     = upd_pc[PC_W-1:BTB_IW+2];
   assign lk_pidx    = pc_in[BHT_IW+1:2];
   assign up_pidx    = upd_pc[BHT_IW+1:2];

`ifdef GSHARE_BRANCH_PREDICTOR_GSHARE_EN
   logic [GHR_W-1:0] ghr;

   assign lk_bidx  = lk_pidx ^ BHT_IW'(ghr);
   assign up_bidx  = up_pidx ^ BHT_IW'(upd_ghr);
   assign pred_ghr = ghr;

   // Non-speculative history: shifts only on resolved branches
   always_ff @(posedge clk) begin
      if (!reset)
         ghr <= '0;
      else if (res_branch)
         ghr <= GHR_W'({ghr, actual_taken});
   end

   assign unused_bits = ^{pc_in[1:0], upd_pc[1:0]};
`else
   assign lk_bidx  = lk_pidx;
   assign up_bidx  = up_pidx;
   assign pred_ghr = '0;

   assign unused_bits = ^{pc_in[1:0], upd_pc[1:0], upd_ghr};
`endif

   assign res_branch = upd_valid && upd_is_branch;
   assign btb_wr     = res_branch && upd_taken;
   assign btb_inv    = upd_valid && !upd_is_branch && upd_btb_hit;

   bpu_btb_array #(
      .ENTRIES (BTB_ENTRIES),
      .TAG_W   (TAG_W),
      .DATA_W  (PC_W)
   ) u_btb (
      .clk      (clk),
      .reset    (reset),
      .rd_idx   (lk_btb_idx),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_target),
      .wr_en    (btb_wr),
      .wr_idx   (up_btb_idx),
      .wr_tag   (up_tag),
      .wr_data  (upd_target),
      .inv_en   (btb_inv),
      .inv_idx  (up_btb_idx)
   );

   // Lookup: hit needs valid entry with matching tag
   always_comb begin
      btb_hit        = rd_valid && (rd_tag == lk_tag);
      predict_target = btb_hit ? rd_target : '0;
      predict_taken  = btb_hit && bht[lk_bidx][1];
   end

   // Resolution judgement on the EX/MEM instruction
   always_comb begin
      actual_taken = res_branch && upd_taken;
      bpu_correct  = !upd_valid ||
                     ((upd_pred_taken == actual_taken) &&
                      (!actual_taken ||
                       (upd_pred_target == upd_target)));
      mispredict   = upd_valid && !bpu_correct;
   end

   // Direction counters, trained on every resolved branch
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < BHT_ENTRIES; i++)
            bht[i] <= CTR_INIT;
      end else if (res_branch) begin
         bht[up_bidx] <= ctr_next(bht[up_bidx], upd_taken);
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk) begin
      if (!reset) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else begin
         if (res_branch)
            branch_cnt <= sat_inc16(branch_cnt);
         if (mispredict)
            mispred_cnt <= sat_inc16(mispred_cnt);
      end
   end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed table-driven bench for gshare_branch_predictor
// (default build; gshare sequence when the macro is defined).
module tb_gshare_branch_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] pc_in;
   logic        predict_taken;
   logic        btb_hit;
   logic [11:0] predict_target;
   logic [5:0]  pred_ghr;
   logic        upd_valid;
   logic [11:0] upd_pc;
   logic        upd_is_branch;
   logic        upd_taken;
   logic [11:0] upd_target;
   logic        upd_pred_taken;
   logic [11:0] upd_pred_target;
   logic        upd_btb_hit;
   logic [5:0]  upd_ghr;
   logic        actual_taken;
   logic        bpu_correct;
   logic        mispredict;
   logic [15:0] branch_cnt;
   logic [15:0] mispred_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gshare_branch_predictor dut (
      .clk             (clk),
      .reset           (reset),
      .pc_in           (pc_in),
      .predict_taken   (predict_taken),
      .btb_hit         (btb_hit),
      .predict_target  (predict_target),
      .pred_ghr        (pred_ghr),
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_is_branch   (upd_is_branch),
      .upd_taken       (upd_taken),
      .upd_target      (upd_target),
      .upd_pred_taken  (upd_pred_taken),
      .upd_pred_target (upd_pred_target),
      .upd_btb_hit     (upd_btb_hit),
      .upd_ghr         (upd_ghr),
      .actual_taken    (actual_taken),
      .bpu_correct     (bpu_correct),
      .mispredict      (mispredict),
      .branch_cnt      (branch_cnt),
      .mispred_cnt     (mispred_cnt)
   );

   typedef struct {
      logic [11:0] pc;
      logic        uv;
      logic        ub;
      logic        ut;
      logic [11:0] utgt;
      logic        upt;
      logic [11:0] uptgt;
      logic        uhit;
      logic        e_hit;
      logic        e_tk;
      logic [11:0] e_tgt;
      logic        e_act;
      logic        e_corr;
      logic        e_mis;
      int          e_bcnt;
      int          e_mcnt;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [11:0] pc, input logic uv,
                        input logic ub, input logic ut,
                        input logic [11:0] utgt, input logic upt,
                        input logic [11:0] uptgt, input logic uhit,
                        input logic [5:0] ghr);
      pc_in           = pc;
      upd_valid       = uv;
      upd_pc          = pc;
      upd_is_branch   = ub;
      upd_taken       = ut;
      upd_target      = utgt;
      upd_pred_taken  = upt;
      upd_pred_target = uptgt;
      upd_btb_hit     = uhit;
      upd_ghr         = ghr;
   endtask

   task automatic idle(input logic [11:0] pc);
      drive(pc, 1'b0, 1'b0, 1'b0, 12'h0, 1'b0, 12'h0, 1'b0, 6'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      idle(12'h040);
      @(posedge clk);
      repeat (2) tick();
      reset = 1'b1;
      #2;
      chk("rst_hit", btb_hit, 0);
      chk("rst_taken", predict_taken, 0);
      chk("rst_target", predict_target, 0);
      chk("rst_ghr", pred_ghr, 0);
      chk("rst_bcnt", branch_cnt, 0);
      chk("rst_mcnt", mispred_cnt, 0);
      tick();

`ifndef GSHARE_BRANCH_PREDICTOR_GSHARE_EN
      vecs[0]  = '{12'h040,0,0,0,12'h000,0,12'h000,0, 0,0,12'h000,0,1,0,0,0};
      vecs[1]  = '{12'h040,1,1,1,12'h100,0,12'h000,0, 0,0,12'h000,1,0,1,0,0};
      vecs[2]  = '{12'h040,1,1,0,12'h000,1,12'h100,1, 1,1,12'h100,0,0,1,1,1};
      vecs[3]  = '{12'h040,1,1,0,12'h000,0,12'h000,1, 1,0,12'h100,0,1,0,2,2};
      vecs[4]  = '{12'h040,1,1,0,12'h000,0,12'h000,1, 1,0,12'h100,0,1,0,3,2};
      vecs[5]  = '{12'h040,1,1,0,12'h000,0,12'h000,1, 1,0,12'h100,0,1,0,4,2};
      vecs[6]  = '{12'h040,1,1,1,12'h200,1,12'h100,1, 1,0,12'h100,1,0,1,5,2};
      vecs[7]  = '{12'h040,1,1,1,12'h200,1,12'h200,1, 1,0,12'h200,1,1,0,6,3};
      vecs[8]  = '{12'h440,0,0,0,12'h000,0,12'h000,0, 0,0,12'h000,0,1,0,7,3};
      vecs[9]  = '{12'h040,1,0,0,12'h000,0,12'h000,1, 1,1,12'h200,0,1,0,7,3};
      vecs[10] = '{12'h040,0,0,0,12'h000,1,12'h005,0, 0,0,12'h000,0,1,0,7,3};
      vecs[11] = '{12'h080,1,0,0,12'h000,1,12'h000,0, 0,0,12'h000,0,0,1,7,3};
      vecs[12] = '{12'h044,1,1,1,12'h300,0,12'h000,0, 0,0,12'h000,1,0,1,7,4};
      vecs[13] = '{12'h044,0,0,0,12'h000,0,12'h000,0, 1,1,12'h300,0,1,0,8,5};
      vecs[14] = '{12'h048,1,1,0,12'h123,0,12'h000,0, 0,0,12'h000,0,1,0,8,5};
      vecs[15] = '{12'h048,0,0,0,12'h000,0,12'h000,0, 0,0,12'h000,0,1,0,9,5};

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].pc, vecs[i].uv, vecs[i].ub, vecs[i].ut,
               vecs[i].utgt, vecs[i].upt, vecs[i].uptgt,
               vecs[i].uhit, 6'h0);
         #2;
         chk($sformatf("v%0d_hit", i), btb_hit, vecs[i].e_hit);
         chk($sformatf("v%0d_taken", i), predict_taken, vecs[i].e_tk);
         chk($sformatf("v%0d_target", i), predict_target, vecs[i].e_tgt);
         chk($sformatf("v%0d_actual", i), actual_taken, vecs[i].e_act);
         chk($sformatf("v%0d_correct", i), bpu_correct, vecs[i].e_corr);
         chk($sformatf("v%0d_mispred", i), mispredict, vecs[i].e_mis);
         chk($sformatf("v%0d_bcnt", i), branch_cnt, vecs[i].e_bcnt);
         chk($sformatf("v%0d_mcnt", i), mispred_cnt, vecs[i].e_mcnt);
         chk($sformatf("v%0d_ghr", i), pred_ghr, 0);
         tick();
      end

      // Update presented during reset is dropped; state is cleared
      reset = 1'b0;
      drive(12'h04C, 1'b1, 1'b1, 1'b1, 12'h3C0, 1'b0, 12'h0, 1'b0, 6'h0);
      tick();
      reset = 1'b1;
      idle(12'h04C);
      #2;
      chk("mrst_hit", btb_hit, 0);
      chk("mrst_bcnt", branch_cnt, 0);
      chk("mrst_mcnt", mispred_cnt, 0);
      pc_in = 12'h044;
      #1;
      chk("mrst_old_hit", btb_hit, 0);
      chk("mrst_old_target", predict_target, 0);
      tick();
      drive(12'h04C, 1'b1, 1'b1, 1'b1, 12'h3C0, 1'b0, 12'h0, 1'b0, 6'h0);
      tick();
      idle(12'h04C);
      #2;
      chk("post_hit", btb_hit, 1);
      chk("post_taken", predict_taken, 1);
      chk("post_target", predict_target, 12'h3C0);
      chk("post_bcnt", branch_cnt, 1);
      chk("post_mcnt", mispred_cnt, 1);
      tick();
`else
      // Three taken branches build history 000111
      drive(12'h060, 1'b1, 1'b1, 1'b1, 12'h080, 1'b0, 12'h0, 1'b0, 6'h0);
      tick();
      drive(12'h100, 1'b1, 1'b1, 1'b1, 12'h010, 1'b0, 12'h0, 1'b0, 6'h0);
      tick();
      drive(12'h100, 1'b1, 1'b1, 1'b1, 12'h010, 1'b0, 12'h0, 1'b0, 6'h0);
      tick();
      idle(12'h000);
      #2;
      chk("gs_ghr3", pred_ghr, 6'b000111);
      chk("gs_bcnt3", branch_cnt, 3);
      // Update at 0x040 with ghr 0x07 trains index 0x17
      drive(12'h040, 1'b1, 1'b1, 1'b1, 12'h200, 1'b0, 12'h0, 1'b0, 6'h07);
      tick();
      idle(12'h060);
      #2;
      chk("gs_ghr4", pred_ghr, 6'b001111);
      chk("gs_hit060", btb_hit, 1);
      chk("gs_taken060", predict_taken, 1);
      chk("gs_target060", predict_target, 12'h080);
      pc_in = 12'h040;
      #1;
      chk("gs_hit040", btb_hit, 1);
      chk("gs_taken040", predict_taken, 0);
      chk("gs_target040", predict_target, 12'h200);
      pc_in = 12'h100;
      #1;
      chk("gs_hit100", btb_hit, 0);
      chk("gs_bcnt4", branch_cnt, 4);
      chk("gs_mcnt4", mispred_cnt, 4);
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
